// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//
// Receive side of the fetch-to-decode interface. Words presented by fetch
// (pcF/instrF) are buffered in a small circular FIFO and handed to decode as
// pcD/instrD/validD. When the queue is full, stallF freezes the fetch PC.
// flushD discards every queued entry and the word fetch is showing this cycle.
//
// Handshakes (one rule for the whole block):
//   enq = !stallF && !flushD  -- fetch has no valid; every unstalled cycle
//                                delivers a word, consumed at the rising edge.
//   deq = validD && !stallD && !flushD -- decode takes the head at the edge.
//   flushD overrides both; the queue is empty in the following cycle.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   pcF, instrF   fetch PC and instruction word
//   stallF        high exactly when the queue holds DEPTH entries
//   flushD        redirect: drop all entries and the current fetch word
//   stallD        decode cannot take the head entry this cycle
//   pcD, instrD   head entry, forced to 0 when validD=0
//   validD        head entry present
//   occupancy     number of stored entries, 0..DEPTH
//   stall_cycles  edges with stallF=1 and flushD=0 (statistics)
//   flush_count   edges with flushD=1 (statistics)
//
// Configuration macro: INSTR_QUEUE_STATS_EN
//   defined   -> stall_cycles / flush_count are live 32-bit wrapping counters
//   undefined -> both outputs are tied to 0 and no counter flops exist
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module instr_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`WORD_WIDTH-1:0] pcF,
    input  logic [`WORD_WIDTH-1:0] instrF,
    output logic                   stallF,
    input  logic                   flushD,
    input  logic                   stallD,
    output logic [`WORD_WIDTH-1:0] pcD,
    output logic [`WORD_WIDTH-1:0] instrD,
    output logic                   validD,
    output logic [CNT_W-1:0]       occupancy,
    output logic [`WORD_WIDTH-1:0] stall_cycles,
    output logic [`WORD_WIDTH-1:0] flush_count
);

    localparam int W     = `WORD_WIDTH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2*W-1:0]   mem_q [DEPTH];
    logic [2*W-1:0]   head;
    logic             enq;
    logic             deq;

    // stallF comes only from the registered count, so there is no
    // combinational path from stallD or flushD back into fetch. A full queue
    // that dequeues this cycle still stalls; the slot frees up next cycle.
    assign stallF    = (count_q == CNT_W'(DEPTH));
    assign validD    = (count_q != '0);
    assign occupancy = count_q;

    assign enq = !stallF && !flushD;
    assign deq = validD && !stallD && !flushD;

    assign head   = mem_q[rd_ptr_q];
    assign pcD    = validD ? head[2*W-1:W] : '0;
    assign instrD = validD ? head[W-1:0]   : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flushD) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow is the modulo wrap.
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every entry is written before count exposes it.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= {pcF, instrF};
    end

`ifdef INSTR_QUEUE_STATS_EN
    logic [W-1:0] stall_cycles_q, stall_cycles_d;
    logic [W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stallF && !flushD) stall_cycles_d = stall_cycles_q + W'(1);
        if (flushD)            flush_count_d  = flush_count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_instr_queue;
  localparam int W     = `WORD_WIDTH;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]     pcF = '0;
  logic [W-1:0]     instrF = '0;
  logic             flushD = 1'b0;
  logic             stallD = 1'b0;
  logic             stallF;
  logic [W-1:0]     pcD;
  logic [W-1:0]     instrD;
  logic             validD;
  logic [CNT_W-1:0] occupancy;
  logic [W-1:0]     stall_cycles;
  logic [W-1:0]     flush_count;

  instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcF          (pcF),
    .instrF       (instrF),
    .stallF       (stallF),
    .flushD       (flushD),
    .stallD       (stallD),
    .pcD          (pcD),
    .instrD       (instrD),
    .validD       (validD),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   fetch_pc = '0;
  int unsigned    exp_stall = 0;
  int unsigned    exp_flush = 0;
  int             checks = 0;
  int             errors = 0;
  int             delivered = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: apply inputs, advance the reference model at the edge.
  task automatic cycle(input logic f, input logic sd);
    logic full, do_enq, do_deq;
    flushD = f;
    stallD = sd;
    pcF    = fetch_pc;
    instrF = 32'h1000 + fetch_pc;
    @(posedge clk);
    full   = (exp_q.size() == DEPTH);
    do_enq = !full && !f;
    do_deq = (exp_q.size() != 0) && !sd && !f;
    if (full && !f) exp_stall++;
    if (f) exp_flush++;
    if (f) begin
      exp_q.delete();
    end else begin
      if (do_deq) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (do_enq) exp_q.push_back({fetch_pc, W'(32'h1000) + fetch_pc});
    end
    if (!full) fetch_pc = fetch_pc + 4;
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("occupancy", W'(occupancy), W'(exp_q.size()));
    chk("stallF", W'(stallF), W'(exp_q.size() == DEPTH));
    chk("validD", W'(validD), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("pcD", pcD, exp_q[0][2*W-1:W]);
      chk("instrD", instrD, exp_q[0][W-1:0]);
    end else begin
      chk("pcD_idle", pcD, '0);
      chk("instrD_idle", instrD, '0);
    end
`ifdef INSTR_QUEUE_STATS_EN
    chk("stall_cycles", stall_cycles, W'(exp_stall));
    chk("flush_count", flush_count, W'(exp_flush));
`else
    chk("stall_cycles_off", stall_cycles, '0);
    chk("flush_count_off", flush_count, '0);
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;

    // Streaming: one word per cycle, occupancy settles at 1.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

    // Redirect to 0 and fill with decode stalled, then hold full a while.
    cycle(1'b1, 1'b0);
    fetch_pc = '0;
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
    chk("fill_pcF_held", pcF, 32'h10);
    // Drain: 0x0, 0x4, 0x8, 0xC, then 0x10 onward.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);

    // Wrap: alternating decode stalls so both pointers cross the end.
    cycle(1'b1, 1'b0);
    fetch_pc = '0;
    for (int i = 0; i < 20; i++) cycle(1'b0, (i % 2) == 0);

    // Flush with three entries queued while fetch shows 0x40.
    cycle(1'b1, 1'b0);
    fetch_pc = '0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    chk("pre_flush_occ", W'(occupancy), W'(3));
    fetch_pc = 32'h40;
    cycle(1'b1, 1'b1);
    fetch_pc = 32'h80;
    chk("post_flush_valid", W'(validD), '0);
    cycle(1'b0, 1'b0);
    chk("redirect_pcD", pcD, 32'h80);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

    // Second fill to accumulate more full-queue cycles.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

    // Async reset between edges with two entries queued.
    cycle(1'b1, 1'b0);
    fetch_pc = 32'h200;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("pre_reset_occ", W'(occupancy), W'(2));
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_stall = 0;
    exp_flush = 0;
    #1;
    chk("arst_validD", W'(validD), '0);
    chk("arst_stallF", W'(stallF), '0);
    chk("arst_pcD", pcD, '0);
    chk("arst_instrD", instrD, '0);
    chk("arst_occupancy", W'(occupancy), '0);
    chk("arst_stall_cycles", stall_cycles, '0);
    chk("arst_flush_count", flush_count, '0);
    @(negedge clk); #1;
    rst = 1'b1;
    fetch_pc = 32'h300;
    cycle(1'b0, 1'b0);
    chk("post_reset_first", pcD, 32'h300);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

    @(negedge clk); #1;
    chk("delivered_nonzero", W'(delivered > 20), W'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: the bench is fixed-length, but never let it run away.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout reached at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
